mdr_ctrl: RTL and testbench
===========================

MDR_CTRL -- requirements
Module: mdr_ctrl

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning).
- clk, in, 1: single clock, all logic on rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- req, in, 2: requester request; bit0 = fetch unit, bit1 = loader port.
- addr0, in, 32: fetch address.
- addr1, in, 32: loader address.
- gnt, out, 2: one-hot grant, held for the whole transaction.
- mem_rd_en, out, 1: instruction memory read strobe.
- mem_addr, out, 32: memory address, registered.
- mem_ack, in, 1: memory data valid on the 67-bit MDR bus.
- mdr_wr, out, 1: drives MDR write enable (capture bus).
- mdr_rd, out, 1: drives MDR read enable (MDR drives bus).
- rsp_valid, out, 1: response available to the granted requester.
- rsp_ready, in, 1: requester accepts the response.
- rsp_id, out, 1: index of the requester being served.
- rsp_err, out, 1: memory timeout flag, meaningful when rsp_valid=1.
- busy, out, 1: high in every state except IDLE.

Function
REQ-002 SHALL implement FSM states IDLE, MEM, LATCH, DRIVE.
REQ-003 IDLE: if req!=0, arbitrate, register the winner's address into mem_addr, set gnt and rsp_id, and go to MEM next cycle; otherwise stay in IDLE.
REQ-004 Arbitration SHALL be two-way round-robin: the requester granted last has lowest priority on a tie; the pointer updates only on a completed response handshake.
REQ-005 MEM: mem_rd_en=1 with mem_addr stable; on mem_ack=1 go to LATCH.
REQ-006 LATCH: mdr_wr=1 for exactly one cycle, then go to DRIVE.
REQ-007 DRIVE: mdr_rd=1 and rsp_valid=1 until rsp_valid&rsp_ready, then go to IDLE and clear gnt.
REQ-008 mdr_wr and mdr_rd SHALL never both be high; mem_rd_en SHALL be high only in MEM.
REQ-009 Latency: with mem_ack sampled in cycle M, mdr_wr is high in M+1 and rsp_valid rises in M+2.
REQ-010 Minimum transaction length is 4 cycles (IDLE, MEM, LATCH, DRIVE); back-to-back grants therefore incur one IDLE cycle.
REQ-011 Deasserting req after grant SHALL NOT abort the transaction; it completes normally.
REQ-012 mem_ack outside MEM SHALL be ignored.
REQ-013 All outputs SHALL be registered, except rsp_valid, mdr_rd and mdr_wr, which decode directly from state.

Reset
REQ-014 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-transaction.
REQ-015 Reset values: gnt=0, mem_rd_en=0, mem_addr=0, mdr_wr=0, mdr_rd=0, rsp_valid=0, rsp_id=0, rsp_err=0, busy=0, round-robin pointer favours requester 0.

Configuration
REQ-016 Macro MDR_CTRL_TIMEOUT_EN defined: a counter runs in MEM; if TIMEOUT_CYC (16) cycles elapse without mem_ack, the FSM skips LATCH and enters DRIVE with rsp_err=1 and mdr_rd=0.
REQ-017 MDR_CTRL_TIMEOUT_EN undefined: no counter, MEM waits indefinitely, rsp_err tied to 0.
REQ-018 The counter SHALL clear on entry to MEM.

Structure
REQ-019 Package mdr_pkg SHALL hold the state enum, INST_W=67, ADDR_W=32 and TIMEOUT_CYC=16.
REQ-020 Arbitration SHALL be a sub-module rr_arb2 (2-bit req, pointer in, one-hot grant out), instantiated once.

Verification
REQ-021 Reset mid-MEM with req=01: after the reset edge, state=IDLE and all outputs are at their reset values.
REQ-022 req=01, addr0=0x100, mem_ack 3 cycles after entering MEM: mem_addr=0x100, one mdr_wr pulse, then rsp_valid with rsp_id=0 until rsp_ready.
REQ-023 req=11 held for 4 transactions with immediate ack and ready: grant order 0,1,0,1.
REQ-024 rsp_ready held low for 5 cycles in DRIVE: rsp_valid and mdr_rd stay high throughout, gnt stable, then IDLE after ready.
REQ-025 req dropped to 00 the cycle after grant: the transaction still completes and rsp_valid is asserted.
REQ-026 Timeout build, mem_ack never asserted: after 16 MEM cycles, rsp_valid=1, rsp_err=1, mdr_wr never pulsed.

Source files
------------

// File: rtl/mdr_pkg.sv
// Shared definitions for the MDR read controller.
//   state_e      : controller FSM states
//   INST_W       : width of the MDR bus carrying fetched instructions
//   ADDR_W       : instruction memory address width
//   TIMEOUT_CYC  : MEM cycles allowed before a read is abandoned (timeout build)
package mdr_pkg;

  localparam int unsigned INST_W      = 67;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMem   = 2'd1,
    StLatch = 2'd2,
    StDrive = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   req : request vector, bit0 = fetch unit, bit1 = loader port
//   ptr : requester that wins a tie (0 or 1)
//   gnt : one-hot grant, zero when nothing is requested
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mdr_ctrl.sv
// MDR read controller: arbitrates fetch unit and loader port for the
// instruction memory, waits for the memory, captures the word into the MDR
// and presents it to the granted requester until it is accepted.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   req[1:0]            : requests (bit0 fetch, bit1 loader)
//   addr0, addr1        : per-requester read addresses
//   gnt[1:0]            : one-hot grant, held for the whole transaction
//   mem_rd_en, mem_addr : memory read strobe and registered address
//   mem_ack             : memory data valid on the MDR bus
//   mdr_wr, mdr_rd      : MDR capture / drive enables
//   rsp_valid/ready     : response handshake, rsp_id = served requester
//   rsp_err             : read abandoned after timeout
//   busy                : controller not idle
// Build option: define MDR_CTRL_TIMEOUT_EN to abandon reads after
// TIMEOUT_CYC cycles in MEM; the response then skips the MDR capture.
module mdr_ctrl
  import mdr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic [1:0]        gnt,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              mdr_wr,
  output logic              mdr_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic              rsp_err,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              rsp_id_q, rsp_id_d;
  logic              busy_q, busy_d;
  logic              ptr_q, ptr_d;
  logic [1:0]        arb_gnt;
  logic              timeout;

  rr_arb2 u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

`ifdef MDR_CTRL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_err_q, rsp_err_d;

  // Counter sits at zero outside MEM, so it is clear on every MEM entry.
  assign timeout = (state_q == StMem) && (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d     = (state_q == StMem) ? cnt_q + 1'b1 : '0;
    rsp_err_d = rsp_err_q;
    if (state_q == StMem && !mem_ack && timeout) begin
      rsp_err_d = 1'b1;
    end else if (state_q == StDrive && rsp_ready) begin
      rsp_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
  // A timed-out response carries no data, so the MDR stays off the bus.
  assign mdr_rd  = (state_q == StDrive) && !rsp_err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
  assign mdr_rd  = (state_q == StDrive);
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    mem_addr_d = mem_addr_q;
    rsp_id_d   = rsp_id_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          state_d    = StMem;
          gnt_d      = arb_gnt;
          mem_addr_d = arb_gnt[1] ? addr1 : addr0;
          rsp_id_d   = arb_gnt[1];
        end
      end
      StMem: begin
        if (mem_ack) begin
          state_d = StLatch;
        end else if (timeout) begin
          state_d = StDrive;
        end
      end
      StLatch: state_d = StDrive;
      StDrive: begin
        if (rsp_ready) begin
          state_d = StIdle;
          gnt_d   = 2'b00;
          // Requester just served loses the next tie.
          ptr_d   = ~rsp_id_q;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered outputs follow the next state so they align with it.
    mem_rd_en_d = (state_d == StMem);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gnt_q       <= 2'b00;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
      rsp_id_q    <= rsp_id_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd_en = mem_rd_en_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;
  assign mdr_wr    = (state_q == StLatch);
  assign rsp_valid = (state_q == StDrive);

endmodule

// File: tb/tb_mdr_ctrl.sv
// Self-checking bench for mdr_ctrl. A transaction-level model predicts the
// winner of each arbitration (round-robin over completed responses), the
// registered address, and the cycle-by-cycle shape of each transaction.
module tb_mdr_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [1:0]  gnt;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mdr_wr;
  logic        mdr_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int prio     = 0;  // model: requester favoured on a tie

  mdr_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr0     (addr0),
    .addr1     (addr1),
    .gnt       (gnt),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mdr_wr    (mdr_wr),
    .mdr_rd    (mdr_rd),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".gnt"}, 32'(gnt), 0);
    check_eq({tag, ".mem_rd_en"}, 32'(mem_rd_en), 0);
    check_eq({tag, ".mem_addr"}, mem_addr, 0);
    check_eq({tag, ".mdr_wr"}, 32'(mdr_wr), 0);
    check_eq({tag, ".mdr_rd"}, 32'(mdr_rd), 0);
    check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
    check_eq({tag, ".rsp_id"}, 32'(rsp_id), 0);
    check_eq({tag, ".rsp_err"}, 32'(rsp_err), 0);
    check_eq({tag, ".busy"}, 32'(busy), 0);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".busy"}, 32'(busy), 0);
    check_eq({tag, ".gnt"}, 32'(gnt), 0);
    check_eq({tag, ".mem_rd_en"}, 32'(mem_rd_en), 0);
    check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
    check_eq({tag, ".mdr_rd"}, 32'(mdr_rd), 0);
    check_eq({tag, ".mdr_wr"}, 32'(mdr_wr), 0);
  endtask

  // One complete transaction starting from IDLE. ack_dly = MEM cycles before
  // mem_ack, rdy_dly = DRIVE cycles before rsp_ready, drop = release req
  // right after the grant.
  task automatic run_txn(input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1,
                         input int ack_dly, input int rdy_dly, input bit drop);
    int          win;
    logic [31:0] ea;
    logic [1:0]  eg;
    win = (r == 2'b11) ? prio : (r[1] ? 1 : 0);
    ea  = (win == 1) ? a1 : a0;
    eg  = (win == 1) ? 2'b10 : 2'b01;
    req       = r;
    addr0     = a0;
    addr1     = a1;
    mem_ack   = 1'($urandom);  // must be ignored in IDLE
    rsp_ready = 1'($urandom);
    check_idle("idle_pre");
    tick();
    if (drop) req = 2'b00;
    addr0 = $urandom;  // registered address must not follow
    addr1 = $urandom;
    for (int i = 0; i <= ack_dly; i++) begin
      mem_ack   = (i == ack_dly);
      rsp_ready = 1'($urandom);
      check_eq("mem.mem_rd_en", 32'(mem_rd_en), 1);
      check_eq("mem.busy", 32'(busy), 1);
      check_eq("mem.gnt", 32'(gnt), 32'(eg));
      check_eq("mem.rsp_id", 32'(rsp_id), 32'(win));
      check_eq("mem.mem_addr", mem_addr, ea);
      check_eq("mem.mdr_wr", 32'(mdr_wr), 0);
      check_eq("mem.rsp_valid", 32'(rsp_valid), 0);
      tick();
    end
    mem_ack   = 1'($urandom);  // must be ignored outside MEM
    rsp_ready = 1'($urandom);
    check_eq("latch.mdr_wr", 32'(mdr_wr), 1);
    check_eq("latch.mdr_rd", 32'(mdr_rd), 0);
    check_eq("latch.rsp_valid", 32'(rsp_valid), 0);
    check_eq("latch.mem_rd_en", 32'(mem_rd_en), 0);
    check_eq("latch.gnt", 32'(gnt), 32'(eg));
    tick();
    for (int i = 0; i <= rdy_dly; i++) begin
      mem_ack   = 1'($urandom);
      rsp_ready = (i == rdy_dly);
      check_eq("drive.rsp_valid", 32'(rsp_valid), 1);
      check_eq("drive.mdr_rd", 32'(mdr_rd), 1);
      check_eq("drive.mdr_wr", 32'(mdr_wr), 0);
      check_eq("drive.mem_rd_en", 32'(mem_rd_en), 0);
      check_eq("drive.gnt", 32'(gnt), 32'(eg));
      check_eq("drive.rsp_id", 32'(rsp_id), 32'(win));
      check_eq("drive.rsp_err", 32'(rsp_err), 0);
      check_eq("drive.busy", 32'(busy), 1);
      tick();
    end
    req       = 2'b00;
    mem_ack   = 1'b0;
    rsp_ready = 1'b0;
    prio      = 1 - win;
    check_idle("idle_post");
  endtask

  initial begin
    int order[4];
    rst_n     = 1'b0;
    req       = 2'b00;
    addr0     = 32'h0;
    addr1     = 32'h0;
    mem_ack   = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    prio  = 0;

    // Idle with no request stays idle.
    tick();
    tick();
    check_idle("no_req");

    // Both requesting, immediate ack and ready: alternating grants 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      order[k] = prio;
      run_txn(2'b11, $urandom, $urandom, 0, 0, 1'b0);
    end
    check_eq("rr_order", {order[0][7:0], order[1][7:0], order[2][7:0], order[3][7:0]},
             32'h00010001);

    // Fetch at 0x100 acked 3 cycles into MEM.
    run_txn(2'b01, 32'h100, $urandom, 3, 0, 1'b0);
    // Ready held off 5 cycles in DRIVE.
    run_txn(2'b10, $urandom, $urandom, 1, 5, 1'b0);
    // Request dropped right after the grant.
    run_txn(2'b01, $urandom, $urandom, 2, 1, 1'b1);

`ifdef MDR_CTRL_TIMEOUT_EN
    // Memory never acks: abandoned after 16 MEM cycles with an error.
    req = 2'b01;
    check_idle("to_pre");
    tick();
    req = 2'b00;
    for (int i = 0; i < 16; i++) begin
      mem_ack = 1'b0;
      check_eq("to.mem_rd_en", 32'(mem_rd_en), 1);
      check_eq("to.mdr_wr", 32'(mdr_wr), 0);
      tick();
    end
    check_eq("to.rsp_valid", 32'(rsp_valid), 1);
    check_eq("to.rsp_err", 32'(rsp_err), 1);
    check_eq("to.mdr_rd", 32'(mdr_rd), 0);
    check_eq("to.mdr_wr", 32'(mdr_wr), 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    prio      = 1;
    check_idle("to_post");
    // Next normal transaction must carry no error.
    run_txn(2'b01, $urandom, $urandom, 0, 0, 1'b0);
`else
    // No timeout: MEM waits as long as the memory needs.
    run_txn(2'b10, $urandom, $urandom, 20, 0, 1'b0);
`endif

    // Reset mid-MEM, after a fetch completion has moved the pointer to 1.
    run_txn(2'b01, $urandom, $urandom, 0, 0, 1'b0);
    req   = 2'b01;
    addr0 = 32'hdead_beef;
    tick();
    check_eq("rst_mid.mem_rd_en", 32'(mem_rd_en), 1);
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_vals("rst_mid");
    tick();
    check_reset_vals("rst_hold");
    rst_n = 1'b1;
    req   = 2'b00;
    prio  = 0;
    // Pointer back to favouring requester 0.
    run_txn(2'b11, $urandom, $urandom, 0, 0, 1'b0);

    // Randomized transactions.
    for (int k = 0; k < 25; k++) begin
      run_txn(2'($urandom_range(1, 3)), $urandom, $urandom, int'($urandom_range(0, 6)),
              int'($urandom_range(0, 4)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
